// File: rtl/fifo_pkg.sv
// Shared helpers and default constants for the single-clock FIFO family.
package fifo_pkg;

  // Default almost-empty threshold; the almost-full default depends on depth.
  localparam int unsigned AEMP_DEF = 1;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((32'd1 << res) < value) begin
      res = res + 1;
    end
    return res;
  endfunction

  function automatic int unsigned aful_def(input int unsigned depth);
    return depth - 1;
  endfunction

endpackage

// File: rtl/ram1r1w_gen.sv
// Simple dual-port RAM: one write port, one registered read port, single clock.
module ram1r1w_gen
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_d, rd_data_q;

  // Array is left unreset; only the read register is cleared so q is defined.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read-first: a same-edge write to rd_addr_i returns the old word.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en_i) begin
      rd_data_d = mem_q[rd_addr_i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fifo1c_gen.sv
// Single-clock FIFO controller with status flags, watermark, optional output
// register stage and optional show-ahead prefetch.
module fifo1c_gen
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned PIPE      = 1,
  parameter int unsigned SHOWAHEAD = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      data,
  input  logic                  wrreq,
  input  logic                  rdreq,
  input  logic                  flush,
  input  logic [clog2(DEPTH):0] aful_thres,
  input  logic [clog2(DEPTH):0] aemp_thres,
  input  logic                  highest_clr,
  output logic [WIDTH-1:0]      q,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [clog2(DEPTH):0] usedw,
  output logic [clog2(DEPTH):0] highest_dw,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned AW = clog2(DEPTH);

  typedef logic [AW:0]   cnt_t;
  typedef logic [AW-1:0] ptr_t;

  localparam cnt_t DepthCnt = cnt_t'(DEPTH);

  ptr_t wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  cnt_t usedw_q, usedw_d, mem_cnt_q, mem_cnt_d, highest_q, highest_d;
  logic empty_q, empty_d, full_q, full_d;
  logic aemp_q, aemp_d, aful_q, aful_d;
  logic ovf_q, ovf_d, udf_q, udf_d;
  logic a_vld_q, a_vld_d, b_vld_q, b_vld_d;
  logic [WIDTH-1:0] q_q, q_d, ram_rdata;
  logic wr_acc, rd_acc, fetch, b_load;

  // Stage A is the RAM read register, stage B the optional output register.
  // Normal mode: A/B valids are one-shot markers of a popped word in flight.
  // Show-ahead: A/B form a prefetch pipe that refills whenever it drains.
  always_comb begin
    rd_acc  = rdreq & ~empty_q & ~flush;
    wr_acc  = wrreq & (~full_q | rd_acc) & ~flush;
    fetch   = 1'b0;
    b_load  = 1'b0;
    a_vld_d = a_vld_q;
    b_vld_d = b_vld_q;
    if (SHOWAHEAD != 0) begin
      if (PIPE != 0) begin
        b_load  = a_vld_q & (~b_vld_q | rd_acc) & ~flush;
        fetch   = (mem_cnt_q != '0) & (~a_vld_q | b_load) & ~flush;
        a_vld_d = fetch | (a_vld_q & ~b_load);
        b_vld_d = b_load | (b_vld_q & ~rd_acc);
      end else begin
        fetch   = (mem_cnt_q != '0) & (~a_vld_q | rd_acc) & ~flush;
        a_vld_d = fetch | (a_vld_q & ~rd_acc);
        b_vld_d = 1'b0;
      end
    end else begin
      fetch   = rd_acc;
      a_vld_d = rd_acc;
      // A word popped before a flush still lands on q.
      b_load  = a_vld_q & (PIPE != 0);
      b_vld_d = 1'b0;
    end
    if (flush) begin
      a_vld_d = 1'b0;
      b_vld_d = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q + ptr_t'(wr_acc);
    rd_ptr_d  = rd_ptr_q + ptr_t'(fetch);
    usedw_d   = usedw_q + cnt_t'(wr_acc) - cnt_t'(rd_acc);
    mem_cnt_d = mem_cnt_q + cnt_t'(wr_acc) - cnt_t'(fetch);
    ovf_d     = wrreq & ~wr_acc & ~flush;
    udf_d     = rdreq & empty_q & ~flush;
    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      usedw_d   = '0;
      mem_cnt_d = '0;
    end
    full_d = (usedw_d == DepthCnt);
    aful_d = (usedw_d >= aful_thres);
    aemp_d = (usedw_d <= aemp_thres);
    if (SHOWAHEAD != 0) begin
      empty_d = ~((PIPE != 0) ? b_vld_d : a_vld_d);
    end else begin
      empty_d = (usedw_d == '0);
    end
    // Clear loads the post-edge occupancy so the watermark never trails usedw.
    if (highest_clr) begin
      highest_d = usedw_d;
    end else begin
      highest_d = (usedw_d > highest_q) ? usedw_d : highest_q;
    end
    q_d = b_load ? ram_rdata : q_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      usedw_q   <= '0;
      mem_cnt_q <= '0;
      highest_q <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      aemp_q    <= 1'b1;
      aful_q    <= 1'b0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      a_vld_q   <= 1'b0;
      b_vld_q   <= 1'b0;
      q_q       <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      usedw_q   <= usedw_d;
      mem_cnt_q <= mem_cnt_d;
      highest_q <= highest_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      aemp_q    <= aemp_d;
      aful_q    <= aful_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      a_vld_q   <= a_vld_d;
      b_vld_q   <= b_vld_d;
      q_q       <= q_d;
    end
  end

  ram1r1w_gen #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_acc),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (data),
    .rd_en_i   (fetch),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (ram_rdata)
  );

  assign q            = (PIPE != 0) ? q_q : ram_rdata;
  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_empty = aemp_q;
  assign almost_full  = aful_q;
  assign usedw        = usedw_q;
  assign highest_dw   = highest_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_fifo1c_gen.sv
// Scoreboard bench for fifo1c_gen: normal mode (PIPE=1) plus a show-ahead instance.
module tb_fifo1c_gen;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] data = '0;
  logic        wrreq = 1'b0, rdreq = 1'b0, flush = 1'b0, highest_clr = 1'b0;
  logic [4:0]  aful_thres = 5'd12, aemp_thres = 5'd3;
  logic [63:0] q;
  logic        empty, full, almost_empty, almost_full, overflow, underflow;
  logic [4:0]  usedw, highest_dw;

  logic [63:0] sa_data = '0;
  logic        sa_wrreq = 1'b0, sa_rdreq = 1'b0, sa_flush = 1'b0, sa_hclr = 1'b0;
  logic [63:0] sa_q;
  logic        sa_empty, sa_full, sa_aemp, sa_aful, sa_ovf, sa_udf;
  logic [4:0]  sa_usedw, sa_hdw;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hw = 0;
  logic [63:0] model[$];
  logic [63:0] exp_q[$];
  int          due_q[$];

  fifo1c_gen #(.WIDTH(64), .DEPTH(DEPTH), .PIPE(1), .SHOWAHEAD(0)) dut (
    .clk(clk), .rst(rst), .data(data), .wrreq(wrreq), .rdreq(rdreq), .flush(flush),
    .aful_thres(aful_thres), .aemp_thres(aemp_thres), .highest_clr(highest_clr),
    .q(q), .empty(empty), .full(full), .almost_empty(almost_empty),
    .almost_full(almost_full), .usedw(usedw), .highest_dw(highest_dw),
    .overflow(overflow), .underflow(underflow)
  );

  fifo1c_gen #(.WIDTH(64), .DEPTH(DEPTH), .PIPE(0), .SHOWAHEAD(1)) dut_sa (
    .clk(clk), .rst(rst), .data(sa_data), .wrreq(sa_wrreq), .rdreq(sa_rdreq),
    .flush(sa_flush), .aful_thres(aful_thres), .aemp_thres(aemp_thres),
    .highest_clr(sa_hclr), .q(sa_q), .empty(sa_empty), .full(sa_full),
    .almost_empty(sa_aemp), .almost_full(sa_aful), .usedw(sa_usedw),
    .highest_dw(sa_hdw), .overflow(sa_ovf), .underflow(sa_udf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: a popped word is due on q two edges after the read was issued.
  initial begin : monitor
    forever begin
      @(negedge clk);
      while (due_q.size() > 0 && due_q[0] <= cyc) begin
        chk("q_data", q, exp_q[0]);
        void'(due_q.pop_front());
        void'(exp_q.pop_front());
      end
    end
  end

  // Called at a negedge: drives one request cycle, updates the model,
  // then checks the registered status one cycle later.
  task automatic op(input bit w, input logic [63:0] wd, input bit r,
                    input bit fl = 1'b0, input bit hc = 1'b0);
    bit rd_ok, wr_ok, e_ovf, e_udf;
    wrreq = w; data = wd; rdreq = r; flush = fl; highest_clr = hc;
    e_ovf = 1'b0;
    e_udf = 1'b0;
    if (fl) begin
      model.delete();
    end else begin
      rd_ok = r && (model.size() > 0);
      wr_ok = w && ((model.size() < DEPTH) || rd_ok);
      e_ovf = w && !wr_ok;
      e_udf = r && !rd_ok;
      if (rd_ok) begin
        exp_q.push_back(model.pop_front());
        due_q.push_back(cyc + 2);
      end
      if (wr_ok) model.push_back(wd);
    end
    if (hc) hw = model.size();
    else if (model.size() > hw) hw = model.size();
    @(negedge clk);
    wrreq = 1'b0; rdreq = 1'b0; flush = 1'b0; highest_clr = 1'b0;
    chk("usedw", usedw, model.size());
    chk("empty", empty, model.size() == 0);
    chk("full", full, model.size() == DEPTH);
    chk("almost_full", almost_full, model.size() >= aful_thres);
    chk("almost_empty", almost_empty, model.size() <= aemp_thres);
    chk("overflow", overflow, e_ovf);
    chk("underflow", underflow, e_udf);
    chk("highest_dw", highest_dw, hw);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_q"}, q, 0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_aemp"}, almost_empty, 1);
    chk({tag, "_aful"}, almost_full, 0);
    chk({tag, "_usedw"}, usedw, 0);
    chk({tag, "_highest"}, highest_dw, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_udf"}, underflow, 0);
  endtask

  initial begin : timeout
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    repeat (2) @(negedge clk);
    chk_reset("reset");
    chk("sa_reset_q", sa_q, 0);
    chk("sa_reset_empty", sa_empty, 1);
    rst = 1'b0;

    // Show-ahead, PIPE=0: head word visible two edges after the write.
    sa_wrreq = 1'b1; sa_data = 64'hA5;
    @(negedge clk);
    chk("sa_empty_after1", sa_empty, 1);
    chk("sa_usedw_after1", sa_usedw, 1);
    sa_data = 64'h3C;
    @(negedge clk);
    sa_wrreq = 1'b0;
    chk("sa_empty_after2", sa_empty, 0);
    chk("sa_q_head", sa_q, 64'hA5);
    chk("sa_usedw_after2", sa_usedw, 2);
    sa_rdreq = 1'b1;
    @(negedge clk);
    chk("sa_q_next", sa_q, 64'h3C);
    chk("sa_empty_next", sa_empty, 0);
    chk("sa_usedw_next", sa_usedw, 1);
    @(negedge clk);
    sa_rdreq = 1'b0;
    chk("sa_empty_drained", sa_empty, 1);
    chk("sa_usedw_drained", sa_usedw, 0);
    chk("sa_underflow", sa_udf, 0);

    // Fill to full, overflow, drain in order, underflow on empty.
    for (int i = 0; i < DEPTH; i++) op(1'b1, 64'(i), 1'b0);
    op(1'b1, 64'hDEAD, 1'b0);
    for (int i = 0; i < DEPTH; i++) op(1'b0, '0, 1'b1);
    op(1'b0, '0, 1'b1);
    op(1'b1, 64'h77, 1'b1);
    op(1'b0, '0, 1'b1);
    op(1'b0, '0, 1'b0);

    // Full FIFO with simultaneous read and write.
    for (int i = 0; i < DEPTH; i++) op(1'b1, 64'h200 + 64'(i), 1'b0);
    op(1'b1, 64'h2FF, 1'b1);
    op(1'b1, 64'h2FE, 1'b0);
    for (int i = 0; i < DEPTH; i++) op(1'b0, '0, 1'b1);
    repeat (2) op(1'b0, '0, 1'b0);

    // Flush with a write pending; watermark survives flush, then clear.
    op(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) op(1'b1, 64'h300 + 64'(i), 1'b0);
    op(1'b1, 64'h3FF, 1'b0, 1'b1);
    op(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Steady write+read traffic wraps both pointers several times.
    for (int i = 0; i < 3; i++) op(1'b1, 64'h400 + 64'(i), 1'b0);
    for (int i = 0; i < 40; i++) op(1'b1, 64'h500 + 64'(i), 1'b1);
    for (int i = 0; i < 3; i++) op(1'b0, '0, 1'b1);
    repeat (2) op(1'b0, '0, 1'b0);

    // Asynchronous reset with 7 words stored.
    for (int i = 0; i < 7; i++) op(1'b1, 64'h600 + 64'(i), 1'b0);
    chk("pre_reset_usedw", usedw, 7);
    #2 rst = 1'b1;
    #1 chk_reset("midreset");
    model.delete();
    hw = 0;
    @(negedge clk);
    rst = 1'b0;
    op(1'b1, 64'h5A5A, 1'b0);
    op(1'b0, '0, 1'b1);
    repeat (3) op(1'b0, '0, 1'b0);

    chk("scoreboard_drained", 64'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
